cmp_eq_ge_seq: RTL and testbench

//   Word-serial equality / magnitude comparator for operands wider than one datapath word.

---
 rtl/cmp_eq_ge_seq.sv | 160 ++++++++++++++++
 tb/tb_cmp_eq_ge_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_eq_ge_seq.sv
// Word-serial EQ/GE comparator for operands spanning several datapath words.
// Words arrive LSB first; per-word flags are folded into a held result.

module CmpEQGE #(
  parameter int width = 8,
  parameter int speed = 2
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             eq,
  output logic             ge
);

  logic [width-1:0] e;
  logic [width-1:0] g;

  assign e = ~(a ^ b);
  assign g = a & ~b;

  if (speed == 0) begin : g_serial
    logic s_eq;
    logic s_gt;
    // Ripple from LSB to MSB; higher bits override lower ones.
    always_comb begin
      s_eq = 1'b1;
      s_gt = 1'b0;
      for (int i = 0; i < width; i++) begin
        s_gt = g[i] | (e[i] & s_gt);
        s_eq = e[i] & s_eq;
      end
    end
    assign eq = s_eq;
    assign ge = s_gt | s_eq;
  end else begin : g_tree
    // Only the root of the prefix is needed, so both log-depth
    // variants collapse to the same balanced reduction tree.
    localparam int P = 1 << $clog2(width);
    logic [2*P-1:1] ne;
    logic [2*P-1:1] ng;
    for (genvar i = 0; i < P; i++) begin : g_leaf
      if (i < width) begin : g_bit
        assign ne[P+i] = e[i];
        assign ng[P+i] = g[i];
      end else begin : g_pad
        assign ne[P+i] = 1'b1;
        assign ng[P+i] = 1'b0;
      end
    end
    for (genvar k = 1; k < P; k++) begin : g_node
      assign ne[k] = ne[2*k] & ne[2*k+1];
      assign ng[k] = ng[2*k+1] | (ne[2*k+1] & ng[2*k]);
    end
    assign eq = ne[1];
    assign ge = ng[1] | ne[1];
  end

endmodule

module cmp_eq_ge_seq #(
  parameter int width = 8,
  parameter int words = 4,
  parameter int speed = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] a_word_i,
  input  logic [width-1:0] b_word_i,
  input  logic             tc_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             EQ_o,
  output logic             GE_o
);

  localparam int CW = (words > 1) ? $clog2(words) : 1;
  localparam logic [CW-1:0] LAST = CW'(words - 1);
  localparam logic [width-1:0] MSB = width'(1) << (width - 1);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic             acc_eq;
  logic             acc_ge;
  logic             tc_q;
  logic             accept;
  logic             first;
  logic             last;
  logic             tc_eff;
  logic [width-1:0] a_x;
  logic [width-1:0] b_x;
  logic             weq;
  logic             wge;
  logic             f_eq;
  logic             f_ge;

  assign in_ready_o  = (state == RUN);
  assign res_valid_o = (state == DONE);
  assign accept      = in_valid_i & in_ready_o;
  assign first       = (cnt == '0);
  assign last        = (cnt == LAST);
  assign tc_eff      = first ? tc_i : tc_q;

  // Sign flip on the top word turns signed compare into unsigned.
  assign a_x = a_word_i ^ ((last & tc_eff) ? MSB : '0);
  assign b_x = b_word_i ^ ((last & tc_eff) ? MSB : '0);

  CmpEQGE #(
    .width(width),
    .speed(speed)
  ) u_cmp (
    .a (a_x),
    .b (b_x),
    .eq(weq),
    .ge(wge)
  );

  assign f_eq = weq & acc_eq;
  assign f_ge = (wge & ~weq) | (weq & acc_ge);

  // Word collection, fold and result handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= RUN;
      cnt    <= '0;
      acc_eq <= 1'b1;
      acc_ge <= 1'b1;
      tc_q   <= 1'b0;
      EQ_o   <= 1'b0;
      GE_o   <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept) begin
            if (first) tc_q <= tc_i;
            if (last) begin
              EQ_o   <= f_eq;
              GE_o   <= f_ge;
              state  <= DONE;
              cnt    <= '0;
              acc_eq <= 1'b1;
              acc_ge <= 1'b1;
            end else begin
              cnt    <= cnt + CW'(1);
              acc_eq <= f_eq;
              acc_ge <= f_ge;
            end
          end
        end
        default: begin
          if (res_ready_i) state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_eq_ge_seq.sv
// Bench for cmp_eq_ge_seq: vector table, corner sequences and
// random operands against an arithmetic reference model.

module tb_cmp_eq_ge_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_w;
  logic [7:0] b_w;
  logic       tc;
  logic       res_valid;
  logic       res_ready;
  logic       eq;
  logic       ge;

  logic       in_valid1;
  logic       in_ready1;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       tc1;
  logic       res_valid1;
  logic       res_ready1;
  logic       eq1;
  logic       ge1;

  cmp_eq_ge_seq #(.width(8), .words(4), .speed(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_word_i   (a_w),
    .b_word_i   (b_w),
    .tc_i       (tc),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .EQ_o       (eq),
    .GE_o       (ge)
  );

  cmp_eq_ge_seq #(.width(8), .words(1), .speed(0)) dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid1),
    .in_ready_o (in_ready1),
    .a_word_i   (a1),
    .b_word_i   (b1),
    .tc_i       (tc1),
    .res_valid_o(res_valid1),
    .res_ready_i(res_ready1),
    .EQ_o       (eq1),
    .GE_o       (ge1)
  );

  int nvec = 0;
  int nmis = 0;
  int acc_cnt = 0;

  always @(posedge clk)
    if (!rst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        tc;
    int          gap;
    logic        eq;
    logic        ge;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic t, output logic e,
                                output logic g);
    e = (a == b);
    if (t) g = ($signed(a) >= $signed(b));
    else   g = (a >= b);
  endfunction

  // Feeds four words; tc is toggled after word 0 to prove it is ignored.
  task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                         input logic t, input int gapmax);
    int gaps;
    int to;
    for (int w = 0; w < 4; w++) begin
      gaps = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
        a_w = 8'($urandom);
        b_w = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      a_w = a[8*w +: 8];
      b_w = b[8*w +: 8];
      tc  = (w == 0) ? t : ~t;
      to = 0;
      while (!in_ready && to < 50) begin
        @(negedge clk);
        to++;
      end
      if (to >= 50) chk("accept_timeout", 32'(to), 32'(0));
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge after the last accept.
  task automatic take_result(input string name, input logic e,
                             input logic g, input int hold);
    chk({name, "_latency"}, 32'(res_valid), 32'(1));
    chk({name, "_eq"}, 32'(eq), 32'(e));
    chk({name, "_ge"}, 32'(ge), 32'(g));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a_w = 8'($urandom);
      b_w = 8'($urandom);
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(res_valid), 32'(1));
      chk({name, "_hold_ready"}, 32'(in_ready), 32'(0));
      chk({name, "_hold_eq"}, 32'(eq), 32'(e));
      chk({name, "_hold_ge"}, 32'(ge), 32'(g));
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, "_released"}, 32'(res_valid), 32'(0));
    chk({name, "_reready"}, 32'(in_ready), 32'(1));
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic        rt;
  logic        xe;
  logic        xg;
  int          c0;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a_w = '0; b_w = '0; tc = 1'b0; res_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; tc1 = 1'b0; res_ready1 = 1'b0;

    tbl[0] = '{32'h12345678, 32'h12345678, 1'b0, 0, 1'b1, 1'b1};
    tbl[1] = '{32'h12345600, 32'h123455FF, 1'b0, 0, 1'b0, 1'b1};
    tbl[2] = '{32'h80000000, 32'h00000001, 1'b1, 0, 1'b0, 1'b0};
    tbl[3] = '{32'h80000000, 32'h00000001, 1'b0, 0, 1'b0, 1'b1};
    tbl[4] = '{32'h12345600, 32'h123455FF, 1'b0, 3, 1'b0, 1'b1};
    tbl[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 0, 1'b0, 1'b1};
    tbl[7] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 2, 1'b0, 1'b1};
    tbl[8] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 0, 1'b0, 1'b1};
    tbl[9] = '{32'h80000000, 32'h80000000, 1'b1, 0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_eq", 32'(eq), 32'(0));
    chk("rst_ge", 32'(ge), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      c0 = acc_cnt;
      send_op(tbl[i].a, tbl[i].b, tbl[i].tc, tbl[i].gap);
      chk($sformatf("tbl%0d_accepts", i), 32'(acc_cnt - c0), 32'(4));
      take_result($sformatf("tbl%0d", i), tbl[i].eq, tbl[i].ge, 0);
    end

    // Result held under backpressure; pulses on in_valid must not land.
    c0 = acc_cnt;
    send_op(32'h12345678, 32'h12345678, 1'b0, 0);
    take_result("hold", 1'b1, 1'b1, 5);
    chk("hold_accepts", 32'(acc_cnt - c0), 32'(4));
    c0 = acc_cnt;
    send_op(32'h00000005, 32'h00000004, 1'b0, 0);
    chk("after_hold_accepts", 32'(acc_cnt - c0), 32'(4));
    take_result("after_hold", 1'b0, 1'b1, 0);

    // Reset in the middle of an operand discards the partial fold.
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_w = 8'hFF;
      b_w = 8'h00;
      tc  = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'(1));
    chk("midrst_res_valid", 32'(res_valid), 32'(0));
    send_op(32'h00000001, 32'h00000002, 1'b0, 0);
    take_result("midrst", 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      case ($urandom_range(3, 0))
        0: rb = $urandom;
        1: rb = ra;
        2: rb = {ra[31:8], 8'($urandom)};
        default: rb = ra ^ 32'h80000000;
      endcase
      rt = 1'($urandom);
      model(ra, rb, rt, xe, xg);
      send_op(ra, rb, rt, 2);
      take_result($sformatf("rnd%0d", n), xe, xg,
                  int'($urandom_range(2, 0)));
    end

    // Single-word configuration: every accept completes an operand.
    for (int n = 0; n < 21; n++) begin
      if (n == 0) begin
        ra = 32'h7F; rb = 32'h80; rt = 1'b1;
      end else begin
        ra = 32'($urandom_range(255, 0));
        rb = (n % 4 == 0) ? ra : 32'($urandom_range(255, 0));
        rt = 1'($urandom);
      end
      xe = (ra[7:0] == rb[7:0]);
      xg = rt ? ($signed(ra[7:0]) >= $signed(rb[7:0]))
              : (ra[7:0] >= rb[7:0]);
      @(negedge clk);
      chk($sformatf("w1_%0d_ready", n), 32'(in_ready1), 32'(1));
      in_valid1 = 1'b1;
      a1 = ra[7:0];
      b1 = rb[7:0];
      tc1 = rt;
      @(negedge clk);
      in_valid1 = 1'b0;
      chk($sformatf("w1_%0d_valid", n), 32'(res_valid1), 32'(1));
      chk($sformatf("w1_%0d_eq", n), 32'(eq1), 32'(xe));
      chk($sformatf("w1_%0d_ge", n), 32'(ge1), 32'(xg));
      res_ready1 = 1'b1;
      @(negedge clk);
      res_ready1 = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
